// File: rtl/mem_access_stage.sv
// Registered MEM stage: issues byte/half/word loads and stores to a multi-cycle
// data memory, stalls upstream while busy, and reports misalignment, timeout and halt.
module mem_access_stage #(
    parameter int                ADDR_W    = 32,
    parameter int                TIMEOUT   = 16,
    parameter logic [ADDR_W-1:0] HALT_ADDR = '1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [31:0]       i_result,
    input  logic              i_writeEnable,
    input  logic [4:0]        i_writeAddress,
    input  logic [5:0]        i_opcode,
    input  logic [ADDR_W-1:0] i_memAddress,
    input  logic [31:0]       i_memWriteData,
    output logic              o_stall,
    output logic              o_memReq,
    output logic              o_memWrite,
    output logic [ADDR_W-1:0] o_memAddress,
    output logic [3:0]        o_memByteEn,
    output logic [31:0]       o_memData,
    input  logic              i_memReady,
    input  logic [31:0]       i_memReadData,
    output logic              o_valid,
    output logic [31:0]       o_result,
    output logic              o_writeEnable,
    output logic [4:0]        o_writeAddress,
    output logic              o_misaligned,
    output logic              o_timeout,
    output logic              o_halted
);

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_LH   = 6'b100001;
    localparam logic [5:0] OP_LHU  = 6'b100101;
    localparam logic [5:0] OP_LB   = 6'b100000;
    localparam logic [5:0] OP_LBU  = 6'b100100;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_SH   = 6'b101001;
    localparam logic [5:0] OP_SB   = 6'b101000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_HALT_REQ, S_HALTED} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    function automatic logic is_load(input logic [5:0] op);
        return op inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return op inside {OP_SW, OP_SH, OP_SB};
    endfunction

    function automatic size_t op_size(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW:          return SZ_W;
            OP_LH, OP_LHU, OP_SH:  return SZ_H;
            default:               return SZ_B;
        endcase
    endfunction

    function automatic logic is_aligned(input size_t sz, input logic [1:0] lo);
        case (sz)
            SZ_W:    return lo == 2'b00;
            SZ_H:    return !lo[0];
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_enable(input size_t sz, input logic [1:0] lo);
        case (sz)
            SZ_W:    return 4'b1111;
            SZ_H:    return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b0001 << lo;
        endcase
    endfunction

    // Replicating the narrow datum means the byte enables alone pick the lane.
    function automatic logic [31:0] steer_store(input size_t sz, input logic [31:0] d);
        case (sz)
            SZ_W:    return d;
            SZ_H:    return {2{d[15:0]}};
            default: return {4{d[7:0]}};
        endcase
    endfunction

    function automatic logic [31:0] extract_load(input size_t sz, input logic uns,
                                                 input logic [1:0] lo, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{lo, 3'b000} +: 8];
        h = rd[{lo[1], 4'b0000} +: 16];
        case (sz)
            SZ_W:    return rd;
            SZ_H:    return uns ? {16'h0000, h} : {{16{h[15]}}, h};
            default: return uns ? {24'h000000, b} : {{24{b[7]}}, b};
        endcase
    endfunction

    state_t            state_q;
    logic [7:0]        cnt_q;
    logic [7:0]        cnt_d;
    logic              mem_req_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [3:0]        mem_be_q;
    logic [31:0]       mem_data_q;
    logic              valid_q;
    logic [31:0]       result_q;
    logic              we_q;
    logic [4:0]        wa_q;
    logic              misaligned_q;
    logic              timeout_q;
    logic              halted_q;

    size_t             lat_size_q;
    logic              lat_uns_q;
    logic [1:0]        lat_lo_q;
    logic              lat_load_q;
    logic              lat_we_q;
    logic [4:0]        lat_wa_q;

    size_t             in_size;
    logic              in_load;
    logic              in_store;
    logic              in_aligned;

    assign in_size    = op_size(i_opcode);
    assign in_load    = is_load(i_opcode);
    assign in_store   = is_store(i_opcode);
    assign in_aligned = is_aligned(in_size, i_memAddress[1:0]);
    assign cnt_d      = cnt_q + 8'd1;

    assign o_stall        = (state_q != S_IDLE);
    assign o_memReq       = mem_req_q;
    assign o_memWrite     = mem_write_q;
    assign o_memAddress   = mem_addr_q;
    assign o_memByteEn    = mem_be_q;
    assign o_memData      = mem_data_q;
    assign o_valid        = valid_q;
    assign o_result       = result_q;
    assign o_writeEnable  = we_q;
    assign o_writeAddress = wa_q;
    assign o_misaligned   = misaligned_q;
    assign o_timeout      = timeout_q;
    assign o_halted       = halted_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_data_q   <= '0;
            valid_q      <= 1'b0;
            result_q     <= '0;
            we_q         <= 1'b0;
            wa_q         <= '0;
            misaligned_q <= 1'b0;
            timeout_q    <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            valid_q      <= 1'b0;
            we_q         <= 1'b0;
            misaligned_q <= 1'b0;
            timeout_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_valid) begin
                        if (i_opcode == OP_HALT) begin
                            state_q     <= S_HALT_REQ;
                            mem_req_q   <= 1'b1;
                            mem_write_q <= 1'b0;
                            mem_addr_q  <= HALT_ADDR;
                            mem_be_q    <= 4'b0000;
                            mem_data_q  <= '1;
                        end else if (in_load || in_store) begin
                            if (in_aligned) begin
                                state_q     <= S_ACCESS;
                                cnt_q       <= '0;
                                mem_req_q   <= 1'b1;
                                mem_write_q <= in_store;
                                mem_addr_q  <= {i_memAddress[ADDR_W-1:2], 2'b00};
                                mem_be_q    <= in_store ? lane_enable(in_size, i_memAddress[1:0]) : 4'b1111;
                                mem_data_q  <= in_store ? steer_store(in_size, i_memWriteData) : '0;
                            end else begin
                                valid_q      <= 1'b1;
                                misaligned_q <= 1'b1;
                                result_q     <= '0;
                            end
                        end else begin
                            valid_q  <= 1'b1;
                            result_q <= i_result;
                            we_q     <= i_writeEnable;
                            wa_q     <= i_writeAddress;
                        end
                    end
                end
                S_ACCESS: begin
                    // Ready wins over the timeout when both land on the same cycle.
                    if (i_memReady || cnt_q == TO_LAST) begin
                        state_q     <= S_IDLE;
                        mem_req_q   <= 1'b0;
                        mem_write_q <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_be_q    <= '0;
                        mem_data_q  <= '0;
                        valid_q     <= 1'b1;
                        if (i_memReady) begin
                            if (lat_load_q) begin
                                we_q     <= lat_we_q;
                                wa_q     <= lat_wa_q;
                                result_q <= extract_load(lat_size_q, lat_uns_q, lat_lo_q, i_memReadData);
                            end
                        end else begin
                            timeout_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_HALT_REQ: begin
                    if (i_memReady) begin
                        state_q    <= S_HALTED;
                        mem_req_q  <= 1'b0;
                        mem_addr_q <= '0;
                        mem_data_q <= '0;
                        halted_q   <= 1'b1;
                    end
                end
                S_HALTED: begin
                    halted_q <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && i_valid) begin
            lat_size_q <= in_size;
            lat_uns_q  <= (i_opcode == OP_LBU) || (i_opcode == OP_LHU);
            lat_lo_q   <= i_memAddress[1:0];
            lat_load_q <= in_load;
            lat_we_q   <= i_writeEnable;
            lat_wa_q   <= i_writeAddress;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomised bench for mem_access_stage with a transaction-level reference model
// and literal spot checks on the documented scenarios.
module tb_mem_access_stage;

    localparam int AW = 32;
    localparam int TO = 4;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_LH   = 6'b100001;
    localparam logic [5:0] OP_LHU  = 6'b100101;
    localparam logic [5:0] OP_LB   = 6'b100000;
    localparam logic [5:0] OP_LBU  = 6'b100100;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_SH   = 6'b101001;
    localparam logic [5:0] OP_SB   = 6'b101000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_valid = 1'b0;
    logic [31:0]   i_result = '0;
    logic          i_writeEnable = 1'b0;
    logic [4:0]    i_writeAddress = '0;
    logic [5:0]    i_opcode = '0;
    logic [AW-1:0] i_memAddress = '0;
    logic [31:0]   i_memWriteData = '0;
    logic          i_memReady = 1'b0;
    logic [31:0]   i_memReadData = '0;
    logic          o_stall, o_memReq, o_memWrite;
    logic [AW-1:0] o_memAddress;
    logic [3:0]    o_memByteEn;
    logic [31:0]   o_memData;
    logic          o_valid;
    logic [31:0]   o_result;
    logic          o_writeEnable;
    logic [4:0]    o_writeAddress;
    logic          o_misaligned, o_timeout, o_halted;

    mem_access_stage #(.ADDR_W(AW), .TIMEOUT(TO), .HALT_ADDR(32'hFFFF_FFFF)) dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .i_result(i_result),
        .i_writeEnable(i_writeEnable), .i_writeAddress(i_writeAddress), .i_opcode(i_opcode),
        .i_memAddress(i_memAddress), .i_memWriteData(i_memWriteData), .o_stall(o_stall),
        .o_memReq(o_memReq), .o_memWrite(o_memWrite), .o_memAddress(o_memAddress),
        .o_memByteEn(o_memByteEn), .o_memData(o_memData), .i_memReady(i_memReady),
        .i_memReadData(i_memReadData), .o_valid(o_valid), .o_result(o_result),
        .o_writeEnable(o_writeEnable), .o_writeAddress(o_writeAddress),
        .o_misaligned(o_misaligned), .o_timeout(o_timeout), .o_halted(o_halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] res;
        logic        we;
        logic [4:0]  wa;
        logic        mis;
        logic        to;
    } exp_t;

    exp_t        expq[$];
    exp_t        cur;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic        chk_en = 1'b0;
    logic [31:0] last_res;
    logic [4:0]  last_wa;
    logic        last_we, last_mis, last_to;
    logic [31:0] cap_addr, cap_data;
    logic [3:0]  cap_be;
    logic        cap_wr;
    int          n_stall;
    logic [5:0]  memops [8] = '{OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sz_of(input logic [5:0] op);
        if (op == OP_LW || op == OP_SW) return 4;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
        return 0;
    endfunction

    function automatic bit is_st(input logic [5:0] op);
        return (op == OP_SW || op == OP_SH || op == OP_SB);
    endfunction

    function automatic logic [31:0] mdl_load(input logic [5:0] op, input logic [1:0] lo,
                                             input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * lo);
        if (sz_of(op) == 1) v = v % 256;
        if (sz_of(op) == 2) v = v % 65536;
        if (op == OP_LB && v >= 128) v = v - 256;
        if (op == OP_LH && v >= 32768) v = v - 65536;
        return v;
    endfunction

    function automatic logic [3:0] mdl_be(input logic [5:0] op, input logic [1:0] lo);
        if (!is_st(op) || sz_of(op) == 4) return 4'hF;
        if (sz_of(op) == 2) return 4'(3 << lo);
        return 4'(1 << lo);
    endfunction

    function automatic logic [31:0] mdl_sdata(input logic [5:0] op, input logic [31:0] wd);
        if (sz_of(op) == 2) return (wd % 65536) * 32'h0001_0001;
        if (sz_of(op) == 1) return (wd % 256) * 32'h0101_0101;
        return wd;
    endfunction

    always @(negedge clk) begin
        if (chk_en && reset) begin
            if (expq.size() > 0 && expq[0].due == cyc) begin
                cur = expq.pop_front();
                chk("wb_valid", o_valid, 1);
                chk("wb_we", o_writeEnable, cur.we);
                if (cur.we) begin
                    chk("wb_result", o_result, cur.res);
                    chk("wb_wa", o_writeAddress, cur.wa);
                end
                chk("wb_misaligned", o_misaligned, cur.mis);
                chk("wb_timeout", o_timeout, cur.to);
                last_res = o_result; last_we = o_writeEnable; last_wa = o_writeAddress;
                last_mis = o_misaligned; last_to = o_timeout;
            end else begin
                chk("quiet_valid", o_valid, 0);
                chk("quiet_misaligned", o_misaligned, 0);
                chk("quiet_timeout", o_timeout, 0);
            end
        end
    end

    task automatic garbage();
        i_valid        = 1'($urandom);
        i_opcode       = ($urandom_range(0, 3) == 0) ? OP_HALT : 6'($urandom);
        i_result       = $urandom;
        i_writeEnable  = 1'($urandom);
        i_writeAddress = 5'($urandom);
        i_memAddress   = $urandom;
        i_memWriteData = $urandom;
    endtask

    task automatic do_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] res, input logic we, input logic [4:0] wa,
                         input int delay, input logic [31:0] rdata);
        exp_t       e;
        int         n;
        logic [1:0] lo;
        bit         done;
        n = sz_of(op); lo = addr[1:0]; done = 0; n_stall = 0;
        i_valid = 1'b1; i_opcode = op; i_result = res; i_writeEnable = we;
        i_writeAddress = wa; i_memAddress = addr; i_memWriteData = wd; i_memReady = 1'b0;
        e.due = cyc + 1; e.res = res; e.we = we; e.wa = wa; e.mis = 1'b0; e.to = 1'b0;
        if (n == 0) begin
            expq.push_back(e);
            @(negedge clk);
            chk("alu_memreq", o_memReq, 0);
            chk("alu_stall", o_stall, 0);
        end else if ((lo % n) != 0) begin
            e.we = 1'b0; e.mis = 1'b1;
            expq.push_back(e);
            @(negedge clk);
            chk("mis_memreq", o_memReq, 0);
            chk("mis_stall", o_stall, 0);
        end else begin
            if (delay >= 1 && delay <= TO) begin
                e.due = cyc + 1 + delay;
                if (is_st(op)) e.we = 1'b0;
                else e.res = mdl_load(op, lo, rdata);
            end else begin
                e.due = cyc + 1 + TO; e.we = 1'b0; e.to = 1'b1;
            end
            expq.push_back(e);
            for (int k = 1; k <= TO && !done; k++) begin
                @(negedge clk);
                garbage();
                chk("acc_stall", o_stall, 1);
                chk("acc_memreq", o_memReq, 1);
                chk("acc_write", o_memWrite, 32'(is_st(op)));
                chk("acc_addr", o_memAddress, addr & ~32'd3);
                chk("acc_byteen", o_memByteEn, mdl_be(op, lo));
                if (is_st(op)) chk("acc_data", o_memData, mdl_sdata(op, wd));
                if (k == 1) begin
                    cap_addr = o_memAddress; cap_be = o_memByteEn;
                    cap_data = o_memData; cap_wr = o_memWrite;
                end
                n_stall++;
                if (k == delay) begin
                    i_memReady = 1'b1; i_memReadData = rdata; done = 1;
                end else begin
                    i_memReadData = $urandom;
                end
            end
            @(negedge clk);
            i_memReady = 1'b0;
            chk("end_memreq", o_memReq, 0);
            chk("end_stall", o_stall, 0);
        end
        i_valid = 1'b0;
    endtask

    initial begin
        logic [5:0]  op;
        logic [31:0] a;
        int          dl;

        #1 reset = 1'b0;
        #1;
        chk("rst_stall", o_stall, 0);
        chk("rst_memreq", o_memReq, 0);
        chk("rst_memsig", {o_memWrite, o_memByteEn, o_memData[23:0]}, 0);
        chk("rst_memaddr", o_memAddress, 0);
        chk("rst_wb", {o_valid, o_writeEnable, o_writeAddress, o_misaligned, o_timeout, o_halted}, 0);
        chk("rst_result", o_result, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        chk_en = 1'b1;

        do_op(6'b000000, 32'h0, 32'h0, 32'h1234, 1'b1, 5'd5, 1, 32'h0);
        #1 chk("lit_alu_result", last_res, 32'h1234);
        chk("lit_alu_wa", last_wa, 5);

        do_op(OP_LB, 32'h103, 32'h0, 32'h0, 1'b1, 5'd9, 3, 32'h80FF_FFFF);
        #1 chk("lit_lb_result", last_res, 32'hFFFF_FF80);
        chk("lit_lb_addr", cap_addr, 32'h100);
        chk("lit_lb_byteen", cap_be, 4'hF);
        chk("lit_lb_stall_cycles", n_stall, 3);
        do_op(OP_LBU, 32'h103, 32'h0, 32'h0, 1'b1, 5'd9, 3, 32'h80FF_FFFF);
        #1 chk("lit_lbu_result", last_res, 32'h0000_0080);

        do_op(OP_SH, 32'h202, 32'hDEAD_BEEF, 32'h0, 1'b1, 5'd3, 1, 32'h0);
        #1 chk("lit_sh_write", cap_wr, 1);
        chk("lit_sh_byteen", cap_be, 4'hC);
        chk("lit_sh_data", cap_data, 32'hBEEF_BEEF);
        chk("lit_sh_we", last_we, 0);

        do_op(OP_LW, 32'h101, 32'h0, 32'h0, 1'b1, 5'd4, 1, 32'h0);
        #1 chk("lit_mis_flag", last_mis, 1);
        chk("lit_mis_we", last_we, 0);

        do_op(OP_LW, 32'h40, 32'h0, 32'h0, 1'b1, 5'd4, 0, 32'h0);
        #1 chk("lit_to_flag", last_to, 1);
        chk("lit_to_stall_cycles", n_stall, TO);
        chk("lit_to_we", last_we, 0);

        do_op(OP_LH, 32'h12, 32'h0, 32'h0, 1'b1, 5'd6, TO, 32'h8001_1234);
        #1 chk("lit_lh_at_limit", last_res, 32'hFFFF_8001);

        i_valid = 1'b1; i_opcode = OP_LW; i_memAddress = 32'h80; i_memReady = 1'b0;
        @(negedge clk);
        i_valid = 1'b0;
        chk("ar_memreq_before", o_memReq, 1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 chk("ar_memreq_drop", o_memReq, 0);
        chk("ar_stall_drop", o_stall, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("ar_idle_after", o_stall, 0);

        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 4) == 0) begin
                garbage();
                i_valid = 1'b0;
                @(negedge clk);
            end
            if ($urandom_range(0, 9) < 2) op = {1'b0, 5'($urandom)};
            else op = memops[$urandom_range(0, 7)];
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            dl = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TO + 1);
            do_op(op, a, $urandom, $urandom, 1'($urandom), 5'($urandom), dl, $urandom);
        end

        i_valid = 1'b1; i_opcode = OP_HALT; i_memReady = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            garbage();
            chk("halt_memreq", o_memReq, 1);
            chk("halt_addr", o_memAddress, 32'hFFFF_FFFF);
            chk("halt_byteen", o_memByteEn, 0);
            chk("halt_data", o_memData, 32'hFFFF_FFFF);
            chk("halt_write", o_memWrite, 0);
            chk("halt_stall", o_stall, 1);
            chk("halt_early", o_halted, 0);
            if (k == 2) i_memReady = 1'b1;
        end
        @(negedge clk);
        i_memReady = 1'b0;
        for (int k = 0; k < 20; k++) begin
            chk("halted_flag", o_halted, 1);
            chk("halted_stall", o_stall, 1);
            chk("halted_memreq", o_memReq, 0);
            garbage();
            i_memReady = 1'($urandom);
            @(negedge clk);
        end
        i_memReady = 1'b0;
        i_valid = 1'b0;
        #2 reset = 1'b0;
        #1 chk("halt_reset_flag", o_halted, 0);
        chk("halt_reset_stall", o_stall, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        do_op(6'b001000, 32'h0, 32'h0, 32'hCAFE, 1'b1, 5'd7, 1, 32'h0);
        #1 chk("lit_recover_result", last_res, 32'hCAFE);

        repeat (3) @(negedge clk);
        #1 chk("queue_drained", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
